// File: rtl/simd_acc_pkg.sv
// Shared types and lane geometry for the SIMD product accumulator.
// Lane tables are indexed [mode][lane]; a width of 0 marks a lane unused in that mode.
package simd_acc_pkg;

    localparam int ACC_W_DEF = 26;
    localparam int NUM_LANES = 4;

    localparam logic [1:0] MODE_FULL = 2'd0;
    localparam logic [1:0] MODE_H1   = 2'd1;
    localparam logic [1:0] MODE_H2   = 2'd2;

    // Row 3 is an unused encoding and maps every lane to width 0.
    localparam int LANE_LSB [0:3][0:3] = '{
        '{0, 0, 0, 0},
        '{0, 8, 0, 0},
        '{0, 4, 8, 14},
        '{0, 0, 0, 0}
    };
    localparam int LANE_WID [0:3][0:3] = '{
        '{18, 0, 0, 0},
        '{8, 10, 0, 0},
        '{4, 4, 6, 4},
        '{0, 0, 0, 0}
    };

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

endpackage

// File: rtl/simd_lane_acc.sv
// Single-lane accumulator: load or add, wrap modulo 2^ACC_W, sticky overflow.
// Next-state values are exported so the top can capture the final sum on the last beat's edge.
module simd_lane_acc #(
    parameter int ACC_W = 26
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             signed_i,
    input  logic [ACC_W-1:0] addend_i,
    output logic [ACC_W-1:0] acc_d_o,
    output logic             ovf_d_o
);

    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [ACC_W:0]   sum;
    logic             ovf_now;

    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, addend_i};
        if (signed_i) begin
            ovf_now = (acc_q[ACC_W-1] == addend_i[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_q[ACC_W-1]);
        end else begin
            ovf_now = sum[ACC_W];
        end
        if (load_i) begin
            acc_d_o = addend_i;
            ovf_d_o = 1'b0;
        end else begin
            acc_d_o = sum[ACC_W-1:0];
            ovf_d_o = ovf_q | ovf_now;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (en_i) begin
            acc_q <= acc_d_o;
            ovf_q <= ovf_d_o;
        end
    end

endmodule

// File: rtl/simd_product_accumulator.sv
// Splits the product word into 1/2/4 lanes and accumulates each over acc_len beats.
// Result registers 1 cycle after the last beat; beats stall while a result waits on out_ready.
module simd_product_accumulator
    import simd_acc_pkg::*;
#(
    parameter int IN_W  = 18,
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    C,
    input  logic               in_signed,
    input  logic               HALF_1,
    input  logic               HALF_2,
    input  logic [LEN_W-1:0]   acc_len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*ACC_W-1:0] acc_out,
    output logic [3:0]         acc_ovf,
    output logic [1:0]         out_mode
);

    acc_state_e       state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [1:0]       mode_q, mode_d;
    logic             signed_q, signed_d;

    logic               out_valid_q, out_valid_d;
    logic [4*ACC_W-1:0] acc_out_q, acc_out_d;
    logic [3:0]         acc_ovf_q, acc_ovf_d;
    logic [1:0]         out_mode_q, out_mode_d;

    logic             accept, finish, first;
    logic [1:0]       in_mode, mode_sel;
    logic             signed_sel;
    logic [IN_W-1:0]  lane_raw;
    logic             lane_sgn;
    int               wid;
    logic [ACC_W-1:0] lane_ext [NUM_LANES];
    logic [ACC_W-1:0] lane_sum [NUM_LANES];
    logic [3:0]       lane_ovf;

    assign in_ready = !(out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign first    = (state_q == ST_IDLE);
    assign in_mode  = HALF_2 ? MODE_H2 : (HALF_1 ? MODE_H1 : MODE_FULL);

    // The first beat uses the live mode/sign; later beats use the latched copy.
    assign mode_sel   = first ? in_mode : mode_q;
    assign signed_sel = first ? in_signed : signed_q;

    always_comb begin
        lane_raw = '0;
        lane_sgn = 1'b0;
        wid      = 0;
        for (int k = 0; k < NUM_LANES; k++) begin
            lane_ext[k] = '0;
            lane_raw    = C >> LANE_LSB[mode_sel][k];
            wid         = LANE_WID[mode_sel][k];
            lane_sgn    = 1'b0;
            if (wid > 0) begin
                lane_sgn = signed_sel & lane_raw[wid-1];
                for (int j = 0; j < ACC_W; j++) begin
                    if (j < wid && j < IN_W) lane_ext[k][j] = lane_raw[j];
                    else                     lane_ext[k][j] = lane_sgn;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        simd_lane_acc #(.ACC_W(ACC_W)) u_lane (
            .clk_i    (clk),
            .reset_i  (reset),
            .en_i     (accept),
            .load_i   (first),
            .signed_i (signed_sel),
            .addend_i (lane_ext[g]),
            .acc_d_o  (lane_sum[g]),
            .ovf_d_o  (lane_ovf[g])
        );
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        len_d    = len_q;
        mode_d   = mode_q;
        signed_d = signed_q;
        finish   = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    mode_d   = in_mode;
                    signed_d = in_signed;
                    len_d    = (acc_len == '0) ? LEN_W'(1) : acc_len;
                    count_d  = LEN_W'(1);
                    if (len_d == LEN_W'(1)) finish = 1'b1;
                    else                    state_d = ST_ACCUM;
                end
                ST_ACCUM: begin
                    count_d = count_q + LEN_W'(1);
                    if (count_d == len_q) begin
                        finish  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid_d = finish | (out_valid_q & ~out_ready);
        acc_out_d   = acc_out_q;
        acc_ovf_d   = acc_ovf_q;
        out_mode_d  = out_mode_q;
        if (finish) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                acc_out_d[k*ACC_W +: ACC_W] = lane_sum[k];
            end
            acc_ovf_d  = lane_ovf;
            out_mode_d = mode_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            len_q       <= '0;
            mode_q      <= MODE_FULL;
            signed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            acc_ovf_q   <= '0;
            out_mode_q  <= MODE_FULL;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            len_q       <= len_d;
            mode_q      <= mode_d;
            signed_q    <= signed_d;
            out_valid_q <= out_valid_d;
            acc_out_q   <= acc_out_d;
            acc_ovf_q   <= acc_ovf_d;
            out_mode_q  <= out_mode_d;
        end
    end

    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign acc_ovf   = acc_ovf_q;
    assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_simd_product_accumulator.sv
// Directed bench for the SIMD product accumulator plus a standalone lane overflow check.
module tb_simd_product_accumulator;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [17:0]  C;
    logic         in_signed;
    logic         HALF_1;
    logic         HALF_2;
    logic [7:0]   acc_len;
    logic         out_valid;
    logic         out_ready;
    logic [103:0] acc_out;
    logic [3:0]   acc_ovf;
    logic [1:0]   out_mode;

    logic         l_en, l_load, l_signed;
    logic [25:0]  l_add, l_acc;
    logic         l_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    simd_product_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .C         (C),
        .in_signed (in_signed),
        .HALF_1    (HALF_1),
        .HALF_2    (HALF_2),
        .acc_len   (acc_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .acc_ovf   (acc_ovf),
        .out_mode  (out_mode)
    );

    simd_lane_acc #(.ACC_W(26)) u_lane (
        .clk_i    (clk),
        .reset_i  (reset),
        .en_i     (l_en),
        .load_i   (l_load),
        .signed_i (l_signed),
        .addend_i (l_add),
        .acc_d_o  (l_acc),
        .ovf_d_o  (l_ovf)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [17:0] c);
        in_valid = 1'b1;
        C        = c;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; C = '0; in_signed = 1'b0;
        HALF_1 = 1'b0; HALF_2 = 1'b0; acc_len = 8'd1; out_ready = 1'b1;
        l_en = 1'b0; l_load = 1'b0; l_signed = 1'b0; l_add = '0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_acc", acc_out, 104'd0);
        chk("rst_ovf", acc_ovf, 4'd0);
        chk("rst_mode", out_mode, 2'd0);
        chk("rst_ready", in_ready, 1'b1);

        // Mode 0 signed: three beats of -1.
        in_signed = 1'b1; acc_len = 8'd3;
        beat(18'h3FFFF); chk("m0_b1_valid", out_valid, 1'b0);
        beat(18'h3FFFF); chk("m0_b2_valid", out_valid, 1'b0);
        beat(18'h3FFFF);
        chk("m0_valid", out_valid, 1'b1);
        chk("m0_acc", acc_out, {78'd0, 26'h3FFFFFD});
        chk("m0_ovf", acc_ovf, 4'd0);
        chk("m0_mode", out_mode, 2'd0);
        step();
        chk("m0_drop", out_valid, 1'b0);

        // Mode 1 unsigned; second-beat mode/sign changes must be ignored.
        HALF_1 = 1'b1; in_signed = 1'b0; acc_len = 8'd2;
        beat({10'd1000, 8'd200});
        HALF_1 = 1'b0; in_signed = 1'b1;
        beat({10'd24, 8'd56});
        chk("m1_valid", out_valid, 1'b1);
        chk("m1_acc", acc_out, {52'd0, 26'd1024, 26'd256});
        chk("m1_mode", out_mode, 2'd1);

        // Mode 2 signed, single beat; HALF_2 outranks HALF_1.
        HALF_1 = 1'b1; HALF_2 = 1'b1; in_signed = 1'b1; acc_len = 8'd1;
        beat(18'b1000_111111_1000_0111);
        chk("m2_valid", out_valid, 1'b1);
        chk("m2_acc", acc_out, {26'h3FFFFF8, 26'h3FFFFFF, 26'h3FFFFF8, 26'd7});
        chk("m2_ovf", acc_ovf, 4'd0);
        chk("m2_mode", out_mode, 2'd2);

        // acc_len=0 behaves as 1, then 255 full-scale unsigned beats.
        HALF_1 = 1'b0; HALF_2 = 1'b0; in_signed = 1'b0; acc_len = 8'd0;
        beat(18'h3FFFF);
        chk("len0_valid", out_valid, 1'b1);
        chk("len0_acc", acc_out, {78'd0, 26'd262143});
        acc_len = 8'd255;
        for (int i = 0; i < 254; i++) beat(18'h3FFFF);
        chk("l255_early", out_valid, 1'b0);
        beat(18'h3FFFF);
        chk("l255_valid", out_valid, 1'b1);
        chk("l255_acc", acc_out, {78'd0, 26'd66846465});
        chk("l255_ovf", acc_ovf, 4'd0);
        step();

        // Backpressure: result held while a new beat waits.
        acc_len = 8'd1; out_ready = 1'b0;
        beat(18'd5);
        chk("bp_valid", out_valid, 1'b1);
        chk("bp_acc", acc_out, {78'd0, 26'd5});
        in_valid = 1'b1; C = 18'd9;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_ready", in_ready, 1'b0);
            chk("bp_hold", acc_out, {78'd0, 26'd5});
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        chk("b2b_valid", out_valid, 1'b1);
        chk("b2b_acc", acc_out, {78'd0, 26'd9});
        step();
        chk("b2b_drop", out_valid, 1'b0);

        // Reset mid-accumulation discards the partial sum.
        acc_len = 8'd4;
        beat(18'd100); beat(18'd100);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rmid_valid", out_valid, 1'b0);
        beat(18'd1); beat(18'd1); beat(18'd1);
        chk("rmid_early", out_valid, 1'b0);
        beat(18'd1);
        chk("rmid_done", out_valid, 1'b1);
        chk("rmid_acc", acc_out, {78'd0, 26'd4});
        step();

        // Lane overflow from a preloaded max pattern, sticky until reload.
        l_en = 1'b1; l_load = 1'b1; l_signed = 1'b0; l_add = 26'h3FFFFFF;
        step();
        l_load = 1'b0; l_add = 26'd1; #1;
        chk("lane_u_wrap", l_acc, 26'd0);
        chk("lane_u_ovf", l_ovf, 1'b1);
        step();
        l_add = 26'd0; #1;
        chk("lane_sticky1", l_ovf, 1'b1);
        step();
        chk("lane_sticky2", l_ovf, 1'b1);
        l_load = 1'b1; l_add = 26'd5; #1;
        chk("lane_reload_ovf", l_ovf, 1'b0);
        chk("lane_reload_acc", l_acc, 26'd5);
        l_signed = 1'b1; l_add = 26'h1FFFFFF;
        step();
        l_load = 1'b0; l_add = 26'd1; #1;
        chk("lane_s_ovf", l_ovf, 1'b1);
        chk("lane_s_acc", l_acc, 26'h2000000);
        l_load = 1'b1; l_add = 26'h3FFFFFF;
        step();
        l_load = 1'b0; #1;
        chk("lane_s_noovf", l_ovf, 1'b0);
        chk("lane_s_m2", l_acc, 26'h3FFFFFE);
        l_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/simd_product_accumulator.md
Name: simd_product_accumulator

Overview:
- Downstream stage of the precision-scalable 9x9 multiplier.
- Consumes its registered 18-bit product word C, split into 1, 2 or 4 independent lanes according to the HALF mode.
- Accumulates each lane over a programmable number of beats, with per-lane sign extension, guard bits and sticky overflow.
- Presents the packed per-lane sums through a valid/ready output handshake.

Parameters:
- IN_W, 18, product word width (A_chop_size+B_chop_size of the upstream multiplier).
- ACC_W, 26, per-lane accumulator width (IN_W + 8 guard bits).
- LEN_W, 8, width of the accumulation-length port.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  product beat present.
- in_ready  output  1  beat accepted when in_valid&&in_ready.
- C  input  IN_W  product word, aligned with in_valid.
- in_signed  input  1  lanes are two's complement (upstream A_sign|B_sign).
- HALF_1  input  1  two-lane mode.
- HALF_2  input  1  four-lane mode; has priority over HALF_1.
- acc_len  input  LEN_W  beats per result; 0 is treated as 1.
- out_valid  output  1  result available.
- out_ready  input  1  result consumed when out_valid&&out_ready.
- acc_out  output  4*ACC_W  lane k sum at [k*ACC_W +: ACC_W].
- acc_ovf  output  4  sticky signed/unsigned overflow per lane.
- out_mode  output  2  mode of the result: 0 full, 1 half1, 2 half2.

Behaviour:
- Lane map. Mode 0: lane0=C[17:0]. Mode 1: lane0=C[7:0], lane1=C[17:8]. Mode 2: lane0=C[3:0], lane1=C[7:4], lane2=C[13:8], lane3=C[17:14].
- Each lane is sign-extended from its own MSB if in_signed, else zero-extended, to ACC_W.
- Unused lanes read 0 and their ovf bit reads 0.
- in_ready = !(out_valid && !out_ready).
- Reset: FSM=IDLE, count=0, all accumulators 0, out_valid=0, acc_out=0, acc_ovf=0, out_mode=0. Reset mid-accumulation discards partial sums. No output is produced.
- FSM IDLE, on accepted beat (first beat):
  - Latch mode, in_signed and max(acc_len,1) into len_q.
  - acc_k = ext(lane_k), ovf cleared, count=1.
  - If len_q==1, go straight to the finish action. Otherwise go to ACCUM.
- FSM ACCUM, on accepted beat:
  - acc_k += ext(lane_k) using the latched mode and signedness. HALF_1/HALF_2/in_signed/acc_len on later beats are ignored.
  - Set ovf_k on two's-complement overflow (signed) or carry-out (unsigned). ovf_k is sticky; the sum wraps modulo 2^ACC_W.
  - count++.
  - When count reaches len_q, perform the finish action.
- Finish action, executed on the accepting edge of the last beat:
  - acc_out/acc_ovf/out_mode <= final values and out_valid <= 1, i.e. 1-cycle latency from the last beat.
  - FSM returns to IDLE.
- Result register is separate from the accumulators, so a new first beat may be accepted the cycle after the last beat, provided in_ready is high.
- out_valid holds, with acc_out stable, until out_ready.
- If out_ready arrives in the same cycle as a new finish, out_valid stays 1 and the new result loads (back-to-back).
- While out_valid && !out_ready, in_ready=0 and no beat is consumed, including first beats.
- in_valid without in_ready leaves all state unchanged.

Decomposition:
- Shared package simd_acc_pkg holds:
  - mode encoding constants MODE_FULL=0, MODE_H1=1, MODE_H2=2;
  - lane LSB/width constant arrays per mode;
  - ACC_W default.
- One sub-module simd_lane_acc, instantiated 4 times: single-lane ACC_W adder with load/add select, signed/unsigned overflow detect and sticky ovf.
- Lane extraction, FSM, counter and output register live in the top.

Test Plan:
- Mode 0 signed, acc_len=3, C=18'h3FFFF x3 -> one out_valid one cycle after beat 3; lane0=26'h3FFFFFD; ovf=0; out_mode=0.
- Mode 1 unsigned, acc_len=2, C={10'd1000,8'd200} then {10'd24,8'd56} -> lane0=256, lane1=1024, lanes2/3=0.
- Mode 2 signed, acc_len=1, C=18'b1000_111111_1000_0111 -> lane0=7, lane1=-8, lane2=-1, lane3=-8; result after one beat.
- Overflow, mode 0 unsigned, acc_len=0 (treated as 1), then acc_len=255 with C=18'h3FFFF every beat:
  - expected sum = 255*262143, which does not wrap, so ovf=0;
  - force a wrap by preloading via a 26-bit max pattern and confirm acc_ovf[0]=1, sticky until the next result.
- Backpressure, mode 0, acc_len=1: hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, result unchanged; on release the next beat is accepted and the new result loads back-to-back.
- Reset asserted mid-ACCUM (count=2 of 4) -> no out_valid; the next 4 beats produce only their own sum.
